// File: rtl/bist_pkg.sv
// Shared types, widths and polynomials for the BIST vector controller family.
package bist_pkg;

  localparam int unsigned VEC_W = 10;
  localparam int unsigned SIG_W = 16;

  // Feedback taps at bits 9 and 6: x^10 + x^7 + 1, period 1023.
  localparam logic [VEC_W-1:0] LFSR_TAPS = 10'h240;
  localparam logic [SIG_W-1:0] SIG_POLY  = 16'h1021;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [VEC_W-1:0] lfsr_next(input logic [VEC_W-1:0] v);
    return {v[VEC_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sisr_compactor.sv
// Serial-input signature register with a ones counter; clear has priority over enable.
module sisr_compactor
  import bist_pkg::*;
#(
  parameter logic [SIG_W-1:0] SIG_INIT = 16'hFFFF,
  parameter int unsigned      CNT_W    = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic             i_data,
  output logic [SIG_W-1:0] o_signature,
  output logic [CNT_W-1:0] o_ones_count
);

  logic [SIG_W-1:0] r_sig;
  logic [CNT_W-1:0] r_ones;
  logic             w_fb;

  assign w_fb = r_sig[SIG_W-1] ^ i_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sig  <= '0;
      r_ones <= '0;
    end else if (i_clear) begin
      r_sig  <= SIG_INIT;
      r_ones <= '0;
    end else if (i_enable) begin
      r_sig  <= {r_sig[SIG_W-2:0], 1'b0} ^ (w_fb ? SIG_POLY : '0);
      r_ones <= r_ones + CNT_W'(i_data);
    end
  end

  assign o_signature  = r_sig;
  assign o_ones_count = r_ones;

endmodule

// File: rtl/bist_vec_ctrl.sv
// BIST controller: drives a 10-input cone from an LFSR and compacts its output.
module bist_vec_ctrl
  import bist_pkg::*;
#(
  parameter int unsigned      NUM_VEC   = 1023,
  parameter logic [VEC_W-1:0] LFSR_SEED = 10'h001,
  parameter logic [SIG_W-1:0] SIG_INIT  = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [VEC_W-1:0] vec_out,
  output logic             vec_valid,
  input  logic             o_in,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic [10:0]      ones_count
);

  localparam logic [VEC_W-1:0] LAST_CNT = VEC_W'(NUM_VEC - 1);

  state_t           r_state;
  logic [VEC_W-1:0] r_vec;
  logic [VEC_W-1:0] r_cnt;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;
  logic             w_clear;
  logic             w_enable;

  // Compactor follows the FSM: cleared on accepted start, fed every non-aborted RUN cycle.
  assign w_clear  = (r_state == IDLE) && start;
  assign w_enable = (r_state == RUN) && !abort;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_vec   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= RUN;
            r_vec   <= LFSR_SEED;
            r_cnt   <= '0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            r_state <= IDLE;
            r_vec   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end else if (r_cnt == LAST_CNT) begin
            r_state <= DONE;
            r_vec   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_vec <= lfsr_next(r_vec);
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  sisr_compactor #(
    .SIG_INIT (SIG_INIT),
    .CNT_W    (11)
  ) u_sisr (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (w_clear),
    .i_enable     (w_enable),
    .i_data       (o_in),
    .o_signature  (signature),
    .o_ones_count (ones_count)
  );

  assign vec_out   = r_vec;
  assign vec_valid = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
